// File: rtl/t05_code_serializer_if.sv
// Codeword-in / bit-serial-out bundle between the traversal stage, the serializer
// and the output writer.
interface t05_code_serializer_if #(
   parameter int PATH_W = 128,
   parameter int LEN_W  = 7
);
   logic              char_found;
   logic [7:0]        char_index;
   logic [PATH_W-1:0] char_path;
   logic [LEN_W-1:0]  track_length;
   logic              finished;
   logic              in_ready;
   logic              bit_out;
   logic              bit_valid;
   logic              bit_ready;
   logic              overflow;
   logic              done;

   modport slave (
      input  char_found, char_index, char_path, track_length, finished, bit_ready,
      output in_ready, bit_out, bit_valid, overflow, done
   );

   modport master (
      output char_found, char_index, char_path, track_length, finished, bit_ready,
      input  in_ready, bit_out, bit_valid, overflow, done
   );
endinterface

// File: rtl/t05_code_serializer.sv
// Buffers completed codewords and streams each one out as a serial record:
// char byte (MSB first), length field (MSB first), then path bits deepest-first.
module t05_code_serializer #(
   parameter int PATH_W = 128,
   parameter int LEN_W  = 7,
   parameter int DEPTH  = 2
) (
   input logic                  clk,
   input logic                  rst,
   t05_code_serializer_if.slave bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int LIW = $clog2(LEN_W);
   localparam int PIW = $clog2(PATH_W);
   localparam int EW  = 8 + LEN_W + PATH_W;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, CHAR, LEN, PATH, DONE} state_t;

   logic [EW-1:0]     mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;
   logic              overflow_q;
   state_t            state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        char_q;
   logic [LEN_W-1:0]  len_q;
   logic [PATH_W-1:0] path_q;
   logic              push, pop, hs;
   logic              bit_valid_c, bit_out_c;

   assign bus.in_ready  = (count_q < DEPTH_C);
   assign push          = bus.char_found & bus.in_ready;
   // The FSM pops the head entry in the same cycle it loads it.
   assign pop           = (state_q == IDLE) && (count_q != '0);
   assign hs            = bit_valid_c & bus.bit_ready;
   assign bus.bit_valid = bit_valid_c;
   assign bus.bit_out   = bit_out_c;
   assign bus.overflow  = overflow_q;
   assign bus.done      = (state_q == DONE) && (count_q == '0) && bus.finished;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.char_index, bus.track_length, bus.char_path};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
         if (bus.char_found && !bus.in_ready) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         char_q  <= '0;
         len_q   <= '0;
         path_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (pop) {char_q, len_q, path_q} <= mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_valid_c = 1'b0;
      bit_out_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d = CHAR;
               cnt_d   = LEN_W'(7);
            end else if (bus.finished) begin
               state_d = DONE;
            end
         end
         CHAR: begin
            bit_valid_c = 1'b1;
            bit_out_c   = char_q[cnt_q[2:0]];
            if (hs) begin
               if (cnt_q == '0) begin
                  state_d = LEN;
                  cnt_d   = LEN_W'(LEN_W - 1);
               end else begin
                  cnt_d = cnt_q - LEN_W'(1);
               end
            end
         end
         LEN: begin
            bit_valid_c = 1'b1;
            bit_out_c   = len_q[cnt_q[LIW-1:0]];
            if (hs) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - LEN_W'(1);
               end else if (len_q == '0) begin
                  state_d = IDLE;
               end else begin
                  state_d = PATH;
                  cnt_d   = len_q - LEN_W'(1);
               end
            end
         end
         PATH: begin
            bit_valid_c = 1'b1;
            bit_out_c   = path_q[cnt_q[PIW-1:0]];
            if (hs) begin
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - LEN_W'(1);
            end
         end
         DONE: begin
            if (!bus.finished) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
